// File: rtl/countdown_timer_ctrl.sv
// Front-panel sequencer: debounced buttons -> count_down_timer set/reset/play/stop pulses plus BCD preset editing.
// Latency: state/pulses update 1 cycle after a button rises; no backpressure, edges inside the 2-cycle post-pulse guard are dropped.
module countdown_timer_ctrl #(
    parameter int BLINK_HALF  = 2_500_000,
    parameter int RING_CYCLES = 50_000_000,
    parameter int HOUR_MAX    = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_start,
    input  logic       tmr_ring,
    input  logic       tmr_counting,
    output logic [7:0] hour_bcd,
    output logic [7:0] minute_bcd,
    output logic [7:0] second_bcd,
    output logic       tmr_set,
    output logic       tmr_reset,
    output logic       tmr_play,
    output logic       tmr_stop,
    output logic [2:0] state,
    output logic [1:0] edit_field,
    output logic       blink
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EDIT_H = 3'd1,
        EDIT_M = 3'd2,
        EDIT_S = 3'd3,
        RUN    = 3'd4,
        PAUSE  = 3'd5,
        RING   = 3'd6
    } state_t;

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int RW = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_HALF - 1);
    localparam logic [RW-1:0] RING_LAST    = RW'(RING_CYCLES - 1);
    localparam logic [7:0]    HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic is_edit(input state_t s);
        return (s == EDIT_H) || (s == EDIT_M) || (s == EDIT_S);
    endfunction

    state_t          state_q, state_nxt;
    logic            mode_q, next_q, up_q, start_q, ring_q, counting_q;
    logic [1:0]      guard_cnt;
    logic [BW-1:0]   blink_cnt;
    logic [RW-1:0]   ring_cnt;
    logic [7:0]      hour_nxt, minute_nxt, second_nxt;
    logic            set_nxt, reset_nxt, play_nxt, stop_nxt;
    logic            guard, mode_e, start_e, next_e, up_e;
    logic            start_act, next_act, up_act, any_btn, ring_rise, cnt_fall;

    // Edges inside the guard window are discarded, not deferred.
    assign guard     = (guard_cnt != 2'd0);
    assign mode_e    = btn_mode  & ~mode_q  & ~guard;
    assign start_e   = btn_start & ~start_q & ~guard;
    assign next_e    = btn_next  & ~next_q  & ~guard;
    assign up_e      = btn_up    & ~up_q    & ~guard;
    assign start_act = start_e & ~mode_e;
    assign next_act  = next_e & ~mode_e & ~start_e;
    assign up_act    = up_e & ~mode_e & ~start_e & ~next_e;
    assign any_btn   = mode_e | start_e | next_e | up_e;
    assign ring_rise = tmr_ring & ~ring_q;
    assign cnt_fall  = ~tmr_counting & counting_q;

    always_comb begin
        state_nxt  = state_q;
        hour_nxt   = hour_bcd;
        minute_nxt = minute_bcd;
        second_nxt = second_bcd;
        set_nxt    = 1'b0;
        reset_nxt  = 1'b0;
        play_nxt   = 1'b0;
        stop_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode_e) begin
                    state_nxt = EDIT_H;
                end else if (start_act) begin
                    play_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            EDIT_H, EDIT_M, EDIT_S: begin
                if (mode_e) begin
                    set_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (next_act) begin
                    state_nxt = (state_q == EDIT_H) ? EDIT_M :
                                (state_q == EDIT_M) ? EDIT_S : EDIT_H;
                end else if (up_act) begin
                    if (state_q == EDIT_H)
                        hour_nxt = bcd_inc(hour_bcd, HOUR_MAX_BCD);
                    else if (state_q == EDIT_M)
                        minute_nxt = bcd_inc(minute_bcd, 8'h59);
                    else
                        second_nxt = bcd_inc(second_bcd, 8'h59);
                end
            end
            RUN: begin
                if (mode_e) begin
                    reset_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (start_act) begin
                    stop_nxt  = 1'b1;
                    state_nxt = PAUSE;
                end else if (ring_rise) begin
                    state_nxt = RING;
                end else if (cnt_fall && !tmr_ring) begin
                    state_nxt = IDLE;
                end
            end
            PAUSE: begin
                if (mode_e) begin
                    reset_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (start_act) begin
                    play_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RING: begin
                if (any_btn || ring_cnt == RING_LAST) begin
                    reset_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hour_bcd   <= 8'h00;
            minute_bcd <= 8'h00;
            second_bcd <= 8'h10;
            tmr_set    <= 1'b0;
            tmr_reset  <= 1'b0;
            tmr_play   <= 1'b0;
            tmr_stop   <= 1'b0;
            mode_q     <= 1'b0;
            next_q     <= 1'b0;
            up_q       <= 1'b0;
            start_q    <= 1'b0;
            ring_q     <= 1'b0;
            counting_q <= 1'b0;
            guard_cnt  <= 2'd0;
            blink_cnt  <= '0;
            blink      <= 1'b0;
            ring_cnt   <= '0;
        end else begin
            state_q    <= state_nxt;
            hour_bcd   <= hour_nxt;
            minute_bcd <= minute_nxt;
            second_bcd <= second_nxt;
            tmr_set    <= set_nxt;
            tmr_reset  <= reset_nxt;
            tmr_play   <= play_nxt;
            tmr_stop   <= stop_nxt;
            mode_q     <= btn_mode;
            next_q     <= btn_next;
            up_q       <= btn_up;
            start_q    <= btn_start;
            ring_q     <= tmr_ring;
            counting_q <= tmr_counting;
            if (set_nxt | reset_nxt | play_nxt | stop_nxt)
                guard_cnt <= 2'd2;
            else if (guard)
                guard_cnt <= guard_cnt - 2'd1;
            // Blink phase restarts only when coming from outside the edit states.
            if (!is_edit(state_nxt) || !is_edit(state_q)) begin
                blink_cnt <= '0;
                blink     <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
            ring_cnt <= (state_q == RING) ? ring_cnt + RW'(1) : '0;
        end
    end

    assign state = state_q;

    always_comb begin
        edit_field = 2'd0;
        case (state_q)
            EDIT_H:  edit_field = 2'd1;
            EDIT_M:  edit_field = 2'd2;
            EDIT_S:  edit_field = 2'd3;
            default: edit_field = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed scenarios plus randomized buttons/timer inputs against a cycle-level behavioural model.
module tb_countdown_timer_ctrl;

    localparam int BLINK_HALF  = 4;
    localparam int RING_CYCLES = 20;
    localparam int HOUR_MAX    = 23;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_next, btn_up, btn_start, tmr_ring, tmr_counting;
    logic [7:0] hour_bcd, minute_bcd, second_bcd;
    logic       tmr_set, tmr_reset, tmr_play, tmr_stop, blink;
    logic [2:0] state;
    logic [1:0] edit_field;

    countdown_timer_ctrl #(
        .BLINK_HALF(BLINK_HALF), .RING_CYCLES(RING_CYCLES), .HOUR_MAX(HOUR_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_start(btn_start),
        .tmr_ring(tmr_ring), .tmr_counting(tmr_counting),
        .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
        .tmr_set(tmr_set), .tmr_reset(tmr_reset), .tmr_play(tmr_play), .tmr_stop(tmr_stop),
        .state(state), .edit_field(edit_field), .blink(blink)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: preset kept as plain integers, timing kept as cycle timestamps.
    int     m_state, m_hh, m_mm, m_ss, m_pulse;  // pulse: 0 none 1 set 2 reset 3 play 4 stop
    longint cyc = 0, last_pulse = -10, edit_t0 = 0, ring_t0 = 0;
    bit     pm, pn, pu, ps, pr, pc;

    logic [33:0] dut_vec;
    assign dut_vec = {state, hour_bcd, minute_bcd, second_bcd,
                      tmr_set, tmr_reset, tmr_play, tmr_stop, edit_field, blink};

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [33:0] exp_vec();
        bit       in_edit;
        logic [1:0] fld;
        bit       bl;
        in_edit = (m_state >= 1) && (m_state <= 3);
        fld     = in_edit ? 2'(m_state) : 2'd0;
        bl      = in_edit ? (((cyc - edit_t0) / BLINK_HALF) % 2 == 1) : 1'b0;
        return {3'(m_state), to_bcd(m_hh), to_bcd(m_mm), to_bcd(m_ss),
                m_pulse == 1, m_pulse == 2, m_pulse == 3, m_pulse == 4, fld, bl};
    endfunction

    task automatic model_clock();
        bit em, es, en, eu, rr, cf;
        int nxt, pulse;
        cyc++;
        if (rst) begin
            m_state = 0; m_hh = 0; m_mm = 0; m_ss = 10; m_pulse = 0;
            last_pulse = -10;
            {pm, pn, pu, ps, pr, pc} = '0;
            return;
        end
        em = btn_mode && !pm;  es = btn_start && !ps;
        en = btn_next && !pn;  eu = btn_up && !pu;
        rr = tmr_ring && !pr;  cf = !tmr_counting && pc;
        {pm, pn, pu, ps, pr, pc} = {btn_mode, btn_next, btn_up, btn_start, tmr_ring, tmr_counting};
        if (cyc - last_pulse <= 2) {em, es, en, eu} = '0;
        if (em) {es, en, eu} = '0;
        else if (es) {en, eu} = '0;
        else if (en) eu = 1'b0;
        nxt = m_state; pulse = 0;
        if (m_state == 0) begin
            if (em) nxt = 1;
            else if (es) begin pulse = 3; nxt = 4; end
        end else if (m_state <= 3) begin
            if (em) begin pulse = 1; nxt = 0; end
            else if (en) nxt = (m_state == 3) ? 1 : m_state + 1;
            else if (eu) begin
                if (m_state == 1) m_hh = (m_hh + 1) % (HOUR_MAX + 1);
                else if (m_state == 2) m_mm = (m_mm + 1) % 60;
                else m_ss = (m_ss + 1) % 60;
            end
        end else if (m_state == 4) begin
            if (em) begin pulse = 2; nxt = 0; end
            else if (es) begin pulse = 4; nxt = 5; end
            else if (rr) nxt = 6;
            else if (cf && !tmr_ring) nxt = 0;
        end else if (m_state == 5) begin
            if (em) begin pulse = 2; nxt = 0; end
            else if (es) begin pulse = 3; nxt = 4; end
        end else begin
            if (em || es || en || eu || (cyc - ring_t0 == RING_CYCLES)) begin pulse = 2; nxt = 0; end
        end
        if (nxt == 6 && m_state != 6) ring_t0 = cyc;
        if (nxt >= 1 && nxt <= 3 && !(m_state >= 1 && m_state <= 3)) edit_t0 = cyc;
        if (pulse != 0) last_pulse = cyc;
        m_state = nxt;
        m_pulse = pulse;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {btn_mode, btn_start, btn_next, btn_up, tmr_ring, tmr_counting} = '0;
        step();
        rst = 1'b0;
    endtask

    // b = {mode, start, next, up}; leaves enough idle cycles for any guard to lapse
    task automatic press(input logic [3:0] b);
        {btn_mode, btn_start, btn_next, btn_up} = b;
        step();
        {btn_mode, btn_start, btn_next, btn_up} = 4'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({state, hour_bcd, minute_bcd, second_bcd} !== {3'd0, 24'h000010}) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", {state, hour_bcd, minute_bcd, second_bcd}, {3'd0, 24'h000010});
        end
        n_cmp++;
        if ({tmr_set, tmr_reset, tmr_play, tmr_stop, edit_field, blink} !== 7'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b want 0", {tmr_set, tmr_reset, tmr_play, tmr_stop, edit_field, blink});
        end
        btn_start = 1'b1;
        step();
        n_cmp++;
        if ({tmr_play, state} !== {1'b1, 3'd4}) begin
            n_bad++; $display("FAIL start_play: got %b want %b", {tmr_play, state}, {1'b1, 3'd4});
        end
        btn_start = 1'b0;
        step();
        n_cmp++;
        if (tmr_play !== 1'b0) begin
            n_bad++; $display("FAIL play_width: got %b want 0", tmr_play);
        end
    endtask

    task automatic test_edit();
        do_reset();
        press(4'b1000);
        n_cmp++;
        if ({state, edit_field} !== {3'd1, 2'd1}) begin
            n_bad++; $display("FAIL enter_edit_h: got %b want %b", {state, edit_field}, {3'd1, 2'd1});
        end
        repeat (24) press(4'b0001);
        n_cmp++;
        if (hour_bcd !== 8'h00) begin
            n_bad++; $display("FAIL hour_wrap: got %h want 00", hour_bcd);
        end
        press(4'b0001);
        press(4'b0010);
        repeat (59) press(4'b0001);
        n_cmp++;
        if (minute_bcd !== 8'h59) begin
            n_bad++; $display("FAIL minute_59: got %h want 59", minute_bcd);
        end
        press(4'b0001);
        n_cmp++;
        if (minute_bcd !== 8'h00) begin
            n_bad++; $display("FAIL minute_wrap: got %h want 00", minute_bcd);
        end
        press(4'b0010);
        repeat (3) press(4'b0001);
        btn_mode = 1'b1;
        step();
        n_cmp++;
        if ({tmr_set, state, hour_bcd, minute_bcd, second_bcd} !== {1'b1, 3'd0, 24'h010013}) begin
            n_bad++; $display("FAIL set_preset: got %h want %h", {tmr_set, state, hour_bcd, minute_bcd, second_bcd}, {1'b1, 3'd0, 24'h010013});
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL edit_model: got %h want %h", dut_vec, exp_vec());
        end
        btn_mode = 1'b0;
        step();
        n_cmp++;
        if (tmr_set !== 1'b0) begin
            n_bad++; $display("FAIL set_width: got %b want 0", tmr_set);
        end
    endtask

    task automatic test_run_pause();
        do_reset();
        press(4'b0100);
        btn_start = 1'b1;
        step();
        n_cmp++;
        if ({tmr_stop, state} !== {1'b1, 3'd5}) begin
            n_bad++; $display("FAIL stop_pause: got %b want %b", {tmr_stop, state}, {1'b1, 3'd5});
        end
        btn_start = 1'b0;
        step(); step();
        btn_start = 1'b1;
        step();
        n_cmp++;
        if ({tmr_play, state} !== {1'b1, 3'd4}) begin
            n_bad++; $display("FAIL play_resume: got %b want %b", {tmr_play, state}, {1'b1, 3'd4});
        end
        btn_start = 1'b0;
        step(); step();
        btn_mode = 1'b1;
        step();
        n_cmp++;
        if ({tmr_reset, state} !== {1'b1, 3'd0}) begin
            n_bad++; $display("FAIL mode_reset: got %b want %b", {tmr_reset, state}, {1'b1, 3'd0});
        end
        btn_mode = 1'b0;
        step(); step();
        press(4'b0100);
        tmr_counting = 1'b1;
        step(); step();
        tmr_counting = 1'b0;
        step();
        n_cmp++;
        if ({state, tmr_set, tmr_reset, tmr_play, tmr_stop} !== 7'b0) begin
            n_bad++; $display("FAIL count_fall_idle: got %b want 0", {state, tmr_set, tmr_reset, tmr_play, tmr_stop});
        end
    endtask

    task automatic test_ring();
        int k;
        do_reset();
        tmr_ring = 1'b1;
        step();
        n_cmp++;
        if (state !== 3'd0) begin
            n_bad++; $display("FAIL ring_ignored_idle: got %0d want 0", state);
        end
        tmr_ring = 1'b0;
        step();
        press(4'b0100);
        tmr_ring = 1'b1;
        step();
        n_cmp++;
        if ({state, tmr_reset} !== {3'd6, 1'b0}) begin
            n_bad++; $display("FAIL enter_ring: got %b want %b", {state, tmr_reset}, {3'd6, 1'b0});
        end
        for (k = 1; k <= 100; k++) begin
            step();
            if (tmr_reset === 1'b1) break;
        end
        n_cmp++;
        if (k != RING_CYCLES) begin
            n_bad++; $display("FAIL ring_timeout: reset after %0d cycles want %0d", k, RING_CYCLES);
        end
        n_cmp++;
        if (state !== 3'd0) begin
            n_bad++; $display("FAIL ring_exit: got %0d want 0", state);
        end
        tmr_ring = 1'b0;
        step();
    endtask

    task automatic test_priority_guard();
        do_reset();
        {btn_mode, btn_start, btn_next, btn_up} = 4'b1101;
        step();
        n_cmp++;
        if ({state, hour_bcd, minute_bcd, second_bcd, tmr_play} !== {3'd1, 24'h000010, 1'b0}) begin
            n_bad++; $display("FAIL same_cycle_priority: got %h want %h", {state, hour_bcd, minute_bcd, second_bcd, tmr_play}, {3'd1, 24'h000010, 1'b0});
        end
        {btn_mode, btn_start, btn_next, btn_up} = 4'b0;
        step(); step();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        btn_start = 1'b1;
        step();
        n_cmp++;
        if ({tmr_play, state} !== {1'b0, 3'd0}) begin
            n_bad++; $display("FAIL guard_drop: got %b want %b", {tmr_play, state}, {1'b0, 3'd0});
        end
        step();
        btn_start = 1'b0;
        step();
        n_cmp++;
        if ({tmr_play, state} !== {1'b0, 3'd0}) begin
            n_bad++; $display("FAIL guard_no_replay: got %b want %b", {tmr_play, state}, {1'b0, 3'd0});
        end
        btn_start = 1'b1;
        step();
        n_cmp++;
        if ({tmr_play, state} !== {1'b1, 3'd4}) begin
            n_bad++; $display("FAIL after_guard: got %b want %b", {tmr_play, state}, {1'b1, 3'd4});
        end
        btn_start = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_edit();
        do_reset();
        press(4'b1000);
        press(4'b0010);
        repeat (5) press(4'b0001);
        n_cmp++;
        if ({state, minute_bcd} !== {3'd2, 8'h05}) begin
            n_bad++; $display("FAIL edit_m_ups: got %h want %h", {state, minute_bcd}, {3'd2, 8'h05});
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({state, hour_bcd, minute_bcd, second_bcd, tmr_set, blink} !== {3'd0, 24'h000010, 2'b00}) begin
            n_bad++; $display("FAIL reset_mid_edit: got %h want %h", {state, hour_bcd, minute_bcd, second_bcd, tmr_set, blink}, {3'd0, 24'h000010, 2'b00});
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({tmr_set, blink} !== 2'b00) begin
            n_bad++; $display("FAIL no_set_after_reset: got %b want 00", {tmr_set, blink});
        end
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ((i % 200) >= 140) begin
                {btn_mode, btn_start, btn_next, btn_up} = 4'b0;
            end else begin
                btn_mode  = ($urandom_range(0, 9) == 0);
                btn_start = ($urandom_range(0, 6) == 0);
                btn_next  = ($urandom_range(0, 4) == 0);
                btn_up    = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 19) == 0) tmr_ring = ~tmr_ring;
            if ($urandom_range(0, 14) == 0) tmr_counting = ~tmr_counting;
            step();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle_%0d: got %h want %h", i, dut_vec, exp_vec());
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {btn_mode, btn_start, btn_next, btn_up, tmr_ring, tmr_counting} = '0;
        test_reset();
        test_edit();
        test_run_pause();
        test_ring();
        test_priority_guard();
        test_reset_mid_edit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
